// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter.
package rf_wb_arbiter_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 16;

  // R0 reads as zero, so writes to it are swallowed.
  localparam int R0_ADDR = 0;

  // Controller states.
  typedef logic [1:0] state_t;
  localparam state_t ST_RUN    = 2'd0;
  localparam state_t ST_DRAIN  = 2'd1;
  localparam state_t ST_HALTED = 2'd2;

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter with a one-bit priority pointer that favours the last loser.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr;

  // One-hot grant. A contested cycle goes to the requester the pointer names.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Only a contested grant moves the pointer, and it always moves to the loser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= 1'b0;
    else if (en && (&req))
      ptr <= ~ptr;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Merges ALU and load writebacks into one register-file write port,
// with a halt/drain sequence and a saturating write counter.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_vld,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_rdy,
  input  logic              b_vld,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_rdy,
  input  logic              hlt,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [DATA_W-1:0] dst,
  output logic              we,
  output logic              drained,
  output logic [15:0]       wr_cnt
);

  state_t            state;
  logic              arb_en;
  logic [1:0]        gnt;
  logic              acc;
  logic              issue;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [15:0]       cnt_q;

  // No grants while reset is held or once halted.
  assign arb_en = rst_n && (state != ST_HALTED);

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (arb_en),
    .req   ({b_vld, a_vld}),
    .gnt   (gnt)
  );

  assign a_rdy    = gnt[0];
  assign b_rdy    = gnt[1];
  assign acc      = |gnt;
  assign sel_addr = gnt[1] ? b_addr : a_addr;
  assign sel_data = gnt[1] ? b_data : a_data;
  // An R0 request is consumed but never reaches the register file.
  assign issue    = acc && (sel_addr != ADDR_W'(R0_ADDR));

  assign drained  = (state == ST_HALTED);
  assign wr_cnt   = cnt_q;

  // Run/drain/halt control. DRAIN is left at the edge where nothing is
  // accepted, so HALTED starts on the first cycle with no request and we = 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN:    if (hlt) state <= ST_DRAIN;
        ST_DRAIN:  if (!a_vld && !b_vld) state <= ST_HALTED;
        ST_HALTED: state <= ST_HALTED;
        default:   state <= ST_RUN;
      endcase
    end
  end

  // Write port register: one-cycle we pulse, address/data hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we       <= 1'b0;
      dst_addr <= '0;
      dst      <= '0;
    end else if (issue) begin
      we       <= 1'b1;
      dst_addr <= sel_addr;
      dst      <= sel_data;
    end else begin
      we       <= 1'b0;
    end
  end

  // Saturating write counter, updated together with the we pulse it counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (issue && (cnt_q != 16'hFFFF))
      cnt_q <= cnt_q + 16'd1;
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: a vector table for single handshakes
// plus hand-written sequences for contention, drain/halt, reset and saturation.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_vld = 1'b0, b_vld = 1'b0, hlt = 1'b0;
  logic [3:0]  a_addr = '0, b_addr = '0;
  logic [15:0] a_data = '0, b_data = '0;
  logic        a_rdy, b_rdy, we, drained;
  logic [3:0]  dst_addr;
  logic [15:0] dst, wr_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.ADDR_W(4), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_vld(a_vld), .a_addr(a_addr), .a_data(a_data), .a_rdy(a_rdy),
    .b_vld(b_vld), .b_addr(b_addr), .b_data(b_data), .b_rdy(b_rdy),
    .hlt(hlt), .dst_addr(dst_addr), .dst(dst), .we(we),
    .drained(drained), .wr_cnt(wr_cnt)
  );

  typedef struct {
    logic        av;
    logic [3:0]  aa;
    logic [15:0] ad;
    logic        bv;
    logic [3:0]  ba;
    logic [15:0] bd;
    logic        e_ardy;
    logic        e_brdy;
    logic        e_we;
    logic [3:0]  e_addr;
    logic [15:0] e_dst;
  } vec_t;

  vec_t vecs[10];
  logic [15:0] exp_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    a_vld = 1'b0; b_vld = 1'b0; hlt = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Pointer trace from reset: 0 ->(v3)1 ->(v4)0 ->(v6)1 ->(v8)0.
    vecs[0] = '{1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0000};
    vecs[1] = '{1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 4'd3, 16'h1234};
    vecs[2] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd0, 16'hFFFF, 1'b0, 1'b1, 1'b0, 4'd3, 16'h1234};
    vecs[3] = '{1'b1, 4'd5, 16'hAAAA, 1'b1, 4'd6, 16'hBBBB, 1'b1, 1'b0, 1'b1, 4'd5, 16'hAAAA};
    vecs[4] = '{1'b1, 4'd5, 16'hAAAA, 1'b1, 4'd6, 16'hBBBB, 1'b0, 1'b1, 1'b1, 4'd6, 16'hBBBB};
    vecs[5] = '{1'b0, 4'd0, 16'h0000, 1'b1, 4'd7, 16'h0007, 1'b0, 1'b1, 1'b1, 4'd7, 16'h0007};
    vecs[6] = '{1'b1, 4'd2, 16'h2222, 1'b1, 4'd9, 16'h9999, 1'b1, 1'b0, 1'b1, 4'd2, 16'h2222};
    vecs[7] = '{1'b1, 4'd1, 16'h1111, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 4'd1, 16'h1111};
    vecs[8] = '{1'b1, 4'd4, 16'h4444, 1'b1, 4'd8, 16'h8888, 1'b0, 1'b1, 1'b1, 4'd8, 16'h8888};
    vecs[9] = '{1'b1, 4'd0, 16'h0DEF, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd8, 16'h8888};

    // Reset state, with a request pending during reset.
    @(negedge clk);
    a_vld = 1'b1; a_addr = 4'd3;
    #1;
    check("rst_a_rdy", a_rdy, 0);
    check("rst_we", we, 0);
    check("rst_dst_addr", dst_addr, 0);
    check("rst_dst", dst, 0);
    check("rst_wr_cnt", wr_cnt, 0);
    check("rst_drained", drained, 0);
    do_reset();

    // Table: each vector is one request cycle followed by one idle cycle.
    exp_cnt = 16'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a_vld = vecs[i].av; a_addr = vecs[i].aa; a_data = vecs[i].ad;
      b_vld = vecs[i].bv; b_addr = vecs[i].ba; b_data = vecs[i].bd;
      #1;
      check($sformatf("v%0d_a_rdy", i), a_rdy, vecs[i].e_ardy);
      check($sformatf("v%0d_b_rdy", i), b_rdy, vecs[i].e_brdy);
      @(negedge clk);
      idle_inputs();
      #1;
      if (vecs[i].e_we) exp_cnt = exp_cnt + 16'd1;
      check($sformatf("v%0d_we", i), we, vecs[i].e_we);
      check($sformatf("v%0d_dst_addr", i), dst_addr, vecs[i].e_addr);
      check($sformatf("v%0d_dst", i), dst, vecs[i].e_dst);
      check($sformatf("v%0d_wr_cnt", i), wr_cnt, exp_cnt);
    end

    // Continuous contention from reset: A, B, A, B, then pointer back at A.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (i > 0) begin
        check($sformatf("alt%0d_we", i), we, 1);
        check($sformatf("alt%0d_dst", i), dst,
              (i % 2 == 1) ? 32'hA000 + 32'(i - 1) : 32'hB000 + 32'(i - 1));
      end
      a_vld = 1'b1; a_addr = 4'd1; a_data = 16'hA000 + 16'(i);
      b_vld = 1'b1; b_addr = 4'd2; b_data = 16'hB000 + 16'(i);
      #1;
      check($sformatf("alt%0d_a_rdy", i), a_rdy, (i % 2 == 0) ? 1 : 0);
      check($sformatf("alt%0d_b_rdy", i), b_rdy, (i % 2 == 1) ? 1 : 0);
    end
    @(negedge clk);
    #1;
    check("alt4_we", we, 1);
    check("alt4_dst_addr", dst_addr, 2);
    check("alt4_dst", dst, 16'hB003);
    check("alt_ptr_end_a_rdy", a_rdy, 1);
    check("alt_ptr_end_b_rdy", b_rdy, 0);
    idle_inputs();
    check("alt_wr_cnt", wr_cnt, 4);

    // Halt with both pending on the same register: drain, last write wins.
    do_reset();
    @(negedge clk);
    hlt = 1'b1;
    a_vld = 1'b1; a_addr = 4'd5; a_data = 16'h0001;
    b_vld = 1'b1; b_addr = 4'd5; b_data = 16'h0002;
    #1;
    check("drn_c0_a_rdy", a_rdy, 1);
    check("drn_c0_b_rdy", b_rdy, 0);
    @(negedge clk);
    hlt = 1'b0; a_vld = 1'b0;
    #1;
    check("drn_c1_b_rdy", b_rdy, 1);
    check("drn_c1_we", we, 1);
    check("drn_c1_dst", dst, 16'h0001);
    check("drn_c1_drained", drained, 0);
    @(negedge clk);
    b_vld = 1'b0;
    #1;
    check("drn_c2_we", we, 1);
    check("drn_c2_dst_addr", dst_addr, 5);
    check("drn_c2_dst", dst, 16'h0002);
    check("drn_c2_drained", drained, 0);
    @(negedge clk);
    #1;
    check("drn_c3_drained", drained, 1);
    check("drn_c3_we", we, 0);
    check("drn_c3_dst", dst, 16'h0002);
    @(negedge clk);
    a_vld = 1'b1; a_addr = 4'd3;
    #1;
    check("hlt_a_rdy", a_rdy, 0);
    @(negedge clk);
    #1;
    check("hlt_we", we, 0);
    check("hlt_drained", drained, 1);
    idle_inputs();

    // Reset mid-stream while a write is on the port and A is still requesting.
    do_reset();
    @(negedge clk);
    a_vld = 1'b1; a_addr = 4'd3; a_data = 16'h5555;
    #1;
    check("mrst_a_rdy", a_rdy, 1);
    @(negedge clk);
    a_data = 16'h6666;
    #1;
    check("mrst_we_before", we, 1);
    rst_n = 1'b0;
    #1;
    check("mrst_we", we, 0);
    check("mrst_wr_cnt", wr_cnt, 0);
    check("mrst_a_rdy_low", a_rdy, 0);
    check("mrst_dst_addr", dst_addr, 0);
    @(negedge clk);
    a_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mrst_rel_we", we, 0);
    @(negedge clk);
    #1;
    check("mrst_rel2_we", we, 0);
    check("mrst_rel2_wr_cnt", wr_cnt, 0);
    a_vld = 1'b1; a_addr = 4'd4; a_data = 16'h7777;
    #1;
    check("mrst_new_a_rdy", a_rdy, 1);
    @(negedge clk);
    a_vld = 1'b0;
    #1;
    check("mrst_new_we", we, 1);
    check("mrst_new_dst", dst, 16'h7777);
    check("mrst_new_wr_cnt", wr_cnt, 1);

    // Counter saturation from a preloaded value.
    @(negedge clk);
    force dut.cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.cnt_q;
    #1;
    check("sat_preload", wr_cnt, 16'hFFFE);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a_vld = 1'b1; a_addr = 4'(k + 1); a_data = 16'(k);
      @(negedge clk);
      a_vld = 1'b0;
      #1;
      check($sformatf("sat%0d_we", k), we, 1);
      check($sformatf("sat%0d_wr_cnt", k), wr_cnt, 16'hFFFF);
    end
    @(negedge clk);
    #1;
    check("sat_hold", wr_cnt, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter ADDR_W, default 4, register-file address width.
REQ-002 Parameter DATA_W, default 16, register-file data width.
REQ-003 clk  input  1  single clock; register-file write on clock high.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 a_vld  input  1  ALU writeback request valid.
REQ-006 a_addr  input  ADDR_W  ALU destination register.
REQ-007 a_data  input  DATA_W  ALU result.
REQ-008 a_rdy  output  1  ALU request accepted this cycle.
REQ-009 b_vld  input  1  memory/load writeback request valid.
REQ-010 b_addr  input  ADDR_W  load destination register.
REQ-011 b_data  input  DATA_W  load data.
REQ-012 b_rdy  output  1  load request accepted this cycle.
REQ-013 hlt  input  1  halt request; drains pending writebacks.
REQ-014 dst_addr  output  ADDR_W  register-file write address.
REQ-015 dst  output  DATA_W  register-file write data.
REQ-016 we  output  1  register-file write enable.
REQ-017 drained  output  1  all writebacks retired, block halted.
REQ-018 wr_cnt  output  16  count of register-file writes issued, saturating.

Function
REQ-019 A transfer occurs on a rising clk edge where x_vld && x_rdy; a_rdy and b_rdy shall never both be 1 in the same cycle.
REQ-020 a_rdy/b_rdy shall be combinational from x_vld, state and priority pointer; x_vld shall not depend on x_rdy.
REQ-021 Only one requester valid in RUN or DRAIN: that requester's rdy = 1.
REQ-022 Both valid: grant goes to the requester named by a 1-bit priority pointer (0 = A, 1 = B); the pointer then flips to the loser; the pointer is unchanged on uncontested grants.
REQ-023 Accepted at edge N -> we = 1, dst_addr/dst = accepted addr/data during cycle N+1 only; otherwise we = 0, dst_addr/dst hold last values.
REQ-024 Accepted request with addr == 0 shall be consumed (rdy = 1) but produce we = 0 (R0 is hardwired zero).
REQ-025 wr_cnt increments by 1 on each cycle with we = 1; saturates at 16'hFFFF.
REQ-026 FSM states RUN, DRAIN, HALTED; RUN -> DRAIN when hlt = 1; DRAIN -> HALTED on the first cycle with a_vld = 0, b_vld = 0 and we = 0; HALTED exits only via reset.
REQ-027 In DRAIN, arbitration continues per REQ-021/022; hlt deasserting in DRAIN does not return to RUN.
REQ-028 In HALTED: a_rdy = b_rdy = 0, we = 0, drained = 1; drained = 0 in every other state.
REQ-029 Same-address requests in one cycle: arbitration unchanged; the later-granted write lands last (last-write-wins).

Reset
REQ-030 rst_n low asynchronously forces state = RUN, pointer = 0, we = 0, dst_addr = 0, dst = 0, wr_cnt = 0, drained = 0; a_rdy/b_rdy = 0 while rst_n low.
REQ-031 A request accepted in the cycle reset asserts is discarded; no write issues after reset release.

Structure
REQ-032 The shared package holds the state enum (RUN, DRAIN, HALTED), ADDR_W/DATA_W defaults and the R0 address constant.
REQ-033 Arbitration shall be a sub-module rr_arb2 (two requests, pointer register, two one-hot grants); the FSM, output register and counter stay in rf_wb_arbiter.

Verification
REQ-034 A only, a_addr = 3, a_data = 16'h1234, one cycle -> a_rdy = 1; next cycle we = 1, dst_addr = 3, dst = 16'h1234; wr_cnt = 1.
REQ-035 A and B both valid for 4 cycles from reset -> grants A, B, A, B; we = 1 on 4 consecutive cycles; pointer ends at 0.
REQ-036 b_vld, b_addr = 0, b_data = 16'hFFFF -> b_rdy = 1; we stays 0; wr_cnt unchanged.
REQ-037 hlt pulse with A and B valid for 2 more cycles -> both retired, then drained = 1 one cycle after the last we; later a_vld = 1 gives a_rdy = 0.
REQ-038 rst_n low mid-stream with a_vld = 1 -> we = 0, wr_cnt = 0 immediately; no write after release until a new handshake.
REQ-039 Force wr_cnt to 16'hFFFE and issue 3 writes -> wr_cnt = 16'hFFFF and holds.
